// File: rtl/fpu_divsqrt_param.sv
// Iterative floating-point divide / square-root unit. Width is configurable,
// results are truncated, denormal inputs are treated as zero.
module fpu_divsqrt_param #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] inpA,
   input  logic [W-1:0] inpB,
   input  logic         operation,
   output logic [W-1:0] res,
   output logic [3:0]   flags,
   output logic         busy,
   output logic         ready
);
   // state | meaning
   // IDLE  | waiting for start
   // PREP  | classify operands, resolve specials or set up the recurrence
   // ITER  | one quotient/root bit per cycle, MAN_W+1 cycles
   // NORM  | exponent range check, write result
   // DONE  | ready pulse; start here is accepted immediately
   typedef enum logic [2:0] {IDLE, PREP, ITER, NORM, DONE} state_t;

   localparam int MW = MAN_W + 1;
   localparam int RW = MW + 3;
   localparam int EW = EXP_W + 3;
   localparam int CW = $clog2(MAN_W + 1);
   localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
   localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
   localparam logic [W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [3:0] F_NV = 4'b1000, F_DZ = 4'b0100, F_OF = 4'b0010, F_UF = 4'b0001;

   state_t state, state_nx;

   logic [W-1:0]           a_r, b_r;
   logic                   op_r, sign_r;
   logic signed [EW-1:0]   exp_r;
   logic [RW-1:0]          rem;
   logic [MW-1:0]          dvs, q;
   logic [2*MW-1:0]        rad;
   logic [CW-1:0]          cnt;

   logic                   sa, sb, za, zb, ia, ib, na, nb;
   logic [EXP_W-1:0]       ea, eb;
   logic [MAN_W-1:0]       fa, fb;
   logic [MW-1:0]          ma, mb;

   assign sa = a_r[W-1];
   assign sb = b_r[W-1];
   assign ea = a_r[W-2:MAN_W];
   assign eb = b_r[W-2:MAN_W];
   assign fa = a_r[MAN_W-1:0];
   assign fb = b_r[MAN_W-1:0];
   assign ma = {1'b1, fa};
   assign mb = {1'b1, fb};
   assign za = (ea == '0);
   assign zb = (eb == '0);
   assign ia = (&ea) && (fa == '0);
   assign ib = (&eb) && (fb == '0);
   assign na = (&ea) && (fa != '0);
   assign nb = (&eb) && (fb != '0);

   logic           spec_hit;
   logic [W-1:0]   spec_res;
   logic [3:0]     spec_flags;

   always_comb begin
      spec_hit   = 1'b1;
      spec_res   = '0;
      spec_flags = '0;
      if (op_r) begin
         if (na)      begin spec_res = QNAN; spec_flags = F_NV; end
         else if (za) spec_res = {sa, {(W-1){1'b0}}};
         else if (sa) begin spec_res = QNAN; spec_flags = F_NV; end
         else if (ia) spec_res = {1'b0, INF_MAG};
         else         spec_hit = 1'b0;
      end else begin
         if (na || nb || (za && zb) || (ia && ib)) begin
            spec_res = QNAN; spec_flags = F_NV;
         end
         else if (ia) spec_res = {sa ^ sb, INF_MAG};
         else if (ib || za) spec_res = {sa ^ sb, {(W-1){1'b0}}};
         else if (zb) begin spec_res = {sa ^ sb, INF_MAG}; spec_flags = F_DZ; end
         else         spec_hit = 1'b0;
      end
   end

   logic signed [EW-1:0] e_div, e_unb, e_sq;
   assign e_div = $signed({3'b000, ea}) - $signed({3'b000, eb}) + BIAS;
   assign e_unb = $signed({3'b000, ea}) - BIAS;
   assign e_sq  = e_unb - EW'(e_unb[0]);

   // Shared restoring step: sqrt brings down two radicand bits per cycle,
   // divide compares the running remainder against the divisor.
   logic [RW-1:0] rem_sh, trial, diff, rem_nx;
   logic          ge;

   always_comb begin
      rem_sh = rem;
      trial  = RW'(dvs);
      if (op_r) begin
         rem_sh = {rem[RW-3:0], rad[2*MW-1 -: 2]};
         trial  = RW'({q, 2'b01});
      end
      ge     = (rem_sh >= trial);
      diff   = rem_sh - trial;
      rem_nx = ge ? diff : rem_sh;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = PREP;
         PREP:    state_nx = spec_hit ? DONE : ITER;
         ITER:    if (cnt == CW'(MAN_W)) state_nx = NORM;
         NORM:    state_nx = DONE;
         DONE:    state_nx = start ? PREP : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r <= '0; b_r <= '0; op_r <= 1'b0; sign_r <= 1'b0; exp_r <= '0;
         rem <= '0; dvs <= '0; q <= '0; rad <= '0; cnt <= '0;
         res <= '0; flags <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_r  <= inpA;
                  b_r  <= inpB;
                  op_r <= operation;
               end
            end
            PREP: begin
               if (spec_hit) begin
                  res   <= spec_res;
                  flags <= spec_flags;
               end else begin
                  cnt <= '0;
                  q   <= '0;
                  dvs <= mb;
                  if (op_r) begin
                     sign_r <= 1'b0;
                     rem    <= '0;
                     exp_r  <= (e_sq >>> 1) + BIAS;
                     rad    <= e_unb[0] ? {ma, 1'b0, {MAN_W{1'b0}}}
                                        : {1'b0, ma, {MAN_W{1'b0}}};
                  end else begin
                     sign_r <= sa ^ sb;
                     rad    <= '0;
                     if (ma < mb) begin
                        rem   <= RW'({ma, 1'b0});
                        exp_r <= e_div - EW'(1);
                     end else begin
                        rem   <= RW'(ma);
                        exp_r <= e_div;
                     end
                  end
               end
            end
            ITER: begin
               q   <= {q[MW-2:0], ge};
               cnt <= cnt + CW'(1);
               rad <= rad << 2;
               rem <= op_r ? rem_nx : {rem_nx[RW-2:0], 1'b0};
            end
            NORM: begin
               if (exp_r >= EMAX) begin
                  res   <= {sign_r, INF_MAG};
                  flags <= F_OF;
               end else if (exp_r[EW-1] || exp_r == '0) begin
                  res   <= {sign_r, {(W-1){1'b0}}};
                  flags <= F_UF;
               end else begin
                  res   <= {sign_r, exp_r[EXP_W-1:0], q[MAN_W-1:0]};
                  flags <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state == PREP) || (state == ITER) || (state == NORM);
   assign ready = (state == DONE);

endmodule

// File: tb/tb_fpu_divsqrt_param.sv
// Directed bench for fpu_divsqrt_param at the default single-precision format.
module tb_fpu_divsqrt_param;
   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] inpA, inpB;
   logic        operation;
   logic [31:0] res;
   logic [3:0]  flags;
   logic        busy, ready;

   int errors = 0;
   int checks = 0;
   int lat, nbusy, rdy_cnt, first_rdy;

   fpu_divsqrt_param #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .start(start), .inpA(inpA), .inpB(inpB),
      .operation(operation), .res(res), .flags(flags), .busy(busy), .ready(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Called 1 time unit after a rising edge; the accepting edge is edge 1.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op);
      inpA = a; inpB = b; operation = op; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_ready(output int n, output int nb);
      n  = 1;
      nb = busy ? 1 : 0;
      while (!ready && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (busy) nb++;
      end
      check("ready_seen", {31'd0, ready}, 32'd1);
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic [31:0] exp_res, input logic [3:0] exp_flags,
                      input int exp_lat);
      int n, nb;
      issue(a, b, op);
      wait_ready(n, nb);
      check({tag, "_res"},   res, exp_res);
      check({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_flags});
      check({tag, "_lat"},   n, exp_lat);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; inpA = '0; inpB = '0; operation = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_res",   res, 32'h0);
      check("rst_flags", {28'd0, flags}, 32'h0);
      check("rst_busy",  {31'd0, busy}, 32'h0);
      check("rst_ready", {31'd0, ready}, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 6.0 / 2.0 with latency and busy window
      issue(32'h40C00000, 32'h40000000, 1'b0);
      wait_ready(lat, nbusy);
      check("div6_2_res",   res, 32'h40400000);
      check("div6_2_flags", {28'd0, flags}, 32'h0);
      check("div6_2_lat",   lat, 27);
      check("div6_2_busy",  nbusy, 26);
      @(posedge clk); #1;
      check("idle_after_done", {30'd0, busy, ready}, 32'h0);

      run("sqrt4", 32'h40800000, 32'h0, 1'b1, 32'h40000000, 4'b0000, 27);
      run("sqrt2", 32'h40000000, 32'h0, 1'b1, 32'h3FB504F3, 4'b0000, 27);

      // 1/3 then back-to-back issue in the DONE cycle
      run("div1_3", 32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAA, 4'b0000, 27);
      issue(32'h40000000, 32'h0, 1'b1);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      wait_ready(lat, nbusy);
      check("b2b_res", res, 32'h3FB504F3);
      check("b2b_lat", lat, 27);

      // Special cases
      run("div1_0",  32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000, 4'b0100, 2);
      run("div0_0",  32'h00000000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, 2);
      run("sqrtm1",  32'hBF800000, 32'h0,        1'b1, 32'h7FC00000, 4'b1000, 2);
      run("sqrtm0",  32'h80000000, 32'h0,        1'b1, 32'h80000000, 4'b0000, 2);
      run("divinf",  32'h7F800000, 32'h40000000, 1'b0, 32'h7F800000, 4'b0000, 2);
      run("divbyinf",32'hC0000000, 32'h7F800000, 1'b0, 32'h80000000, 4'b0000, 2);

      // Exponent range
      run("ovf", 32'h7F000000, 32'h3E800000, 1'b0, 32'h7F800000, 4'b0010, 27);
      run("unf", 32'h00800000, 32'h4B000000, 1'b0, 32'h00000000, 4'b0001, 27);
      run("neg_div", 32'hC0C00000, 32'h40000000, 1'b0, 32'hC0400000, 4'b0000, 27);

      // Reset in the middle of ITER
      issue(32'h40C00000, 32'h40000000, 1'b0);
      repeat (12) @(posedge clk);
      #2;
      check("mid_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_res",   res, 32'h0);
      check("mid_rst_flags", {28'd0, flags}, 32'h0);
      check("mid_rst_busy",  {31'd0, busy}, 32'h0);
      check("mid_rst_ready", {31'd0, ready}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Fresh 6/2 with start pulses while busy; exactly one ready expected
      issue(32'h40C00000, 32'h40000000, 1'b0);
      rdy_cnt = 0; first_rdy = 0;
      for (int n = 2; n <= 40; n++) begin
         start = (n == 6 || n == 16);
         if (start) begin inpA = 32'h3F800000; inpB = 32'h40400000; end
         @(posedge clk); #1;
         if (ready) begin
            rdy_cnt++;
            if (first_rdy == 0) first_rdy = n;
         end
      end
      start = 1'b0;
      check("busy_start_ready_cnt", rdy_cnt, 1);
      check("busy_start_first",     first_rdy, 27);
      check("busy_start_res",       res, 32'h40400000);
      check("busy_start_flags",     {28'd0, flags}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
